// File: rtl/seq_divider_pkg.sv
`default_nettype none
// ============================================================================
// seq_divider_pkg : shared types and constants for the sequential divider
// Revision 1.0
// ============================================================================
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [63:0] DIV0_QUOTIENT = '1;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  function automatic logic [63:0] most_neg(input int unsigned width);
    return 64'd1 << (width - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_divider_lzc.sv
`default_nettype none
// ============================================================================
// seq_divider_lzc : leading-zero counter, returns WIDTH for an all-zero input
// Revision 1.0
// ============================================================================
module seq_divider_lzc #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [CNT_W-1:0] count_o
);

  // Ascending scan so the highest set bit is the last to win
  always_comb begin
    count_o = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (data_i[i]) count_o = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// seq_divider : radix-2 shift-subtract signed/unsigned divider, valid/ready I/O
// Optional SEQ_DIVIDER_EARLY_OUT_EN skips the dividend's leading zeros.
// Revision 1.0
// ============================================================================
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             overflow
);

  localparam logic [63:0]      MOST_NEG_64 = most_neg(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG    = MOST_NEG_64[WIDTH-1:0];
  localparam logic [WIDTH-1:0] DIV0_Q      = DIV0_QUOTIENT[WIDTH-1:0];

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] dvd_q, dvs_q, prem_q;
  logic             neg_quo_q, neg_rem_q, div0_q, ovf_q;
  logic             in_ready_q, out_valid_q, div_zero_q, overflow_q;
  logic [WIDTH-1:0] quotient_q, remainder_q;

  logic             sgn_dvd, sgn_dvs, dvs_zero, sgn_ovf;
  logic [WIDTH-1:0] abs_dvd, abs_dvs;
  logic [WIDTH:0]   shl_rem, sub_rem;
  logic             q_bit;
  logic [WIDTH-1:0] prem_d, dvd_d;

  assign sgn_dvd  = is_signed & dividend[WIDTH-1];
  assign sgn_dvs  = is_signed & divisor[WIDTH-1];
  // Unsigned W-bit magnitude is exact even for the most-negative operand
  assign abs_dvd  = sgn_dvd ? (~dividend + 1'b1) : dividend;
  assign abs_dvs  = sgn_dvs ? (~divisor + 1'b1) : divisor;
  assign dvs_zero = (divisor == '0);
  assign sgn_ovf  = is_signed && (dividend == MOST_NEG) && (divisor == '1);

  // Partial remainder stays below the divisor, so a W+1 bit borrow is a valid compare
  assign shl_rem = {prem_q, dvd_q[WIDTH-1]};
  assign sub_rem = shl_rem - {1'b0, dvs_q};
  assign q_bit   = ~sub_rem[WIDTH];
  assign prem_d  = q_bit ? sub_rem[WIDTH-1:0] : shl_rem[WIDTH-1:0];
  assign dvd_d   = {dvd_q[WIDTH-2:0], q_bit};

`ifdef SEQ_DIVIDER_EARLY_OUT_EN
  logic [CNT_W-1:0] lz;
  logic [CNT_W-1:0] cnt_init;
  logic [WIDTH-1:0] dvd_init;

  seq_divider_lzc #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_lzc (
    .data_i  (abs_dvd),
    .count_o (lz)
  );

  assign cnt_init = (lz == CNT_W'(WIDTH)) ? CNT_W'(1) : (CNT_W'(WIDTH) - lz);
  assign dvd_init = abs_dvd << lz;
`else
  logic [CNT_W-1:0] cnt_init;
  logic [WIDTH-1:0] dvd_init;

  assign cnt_init = CNT_W'(WIDTH);
  assign dvd_init = abs_dvd;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      prem_q      <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      div0_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      div_zero_q  <= 1'b0;
      overflow_q  <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            div_zero_q <= 1'b0;
            overflow_q <= 1'b0;
            neg_quo_q  <= sgn_dvd ^ sgn_dvs;
            neg_rem_q  <= sgn_dvd;
            div0_q     <= dvs_zero;
            ovf_q      <= sgn_ovf;
            dvs_q      <= abs_dvs;
            prem_q     <= '0;
            if (dvs_zero || sgn_ovf) begin
              // Special cases report the raw dividend, so keep it unmodified
              dvd_q   <= dividend;
              cnt_q   <= '0;
              state_q <= FIX;
            end else begin
              dvd_q   <= dvd_init;
              cnt_q   <= cnt_init;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          dvd_q  <= dvd_d;
          prem_q <= prem_d;
          cnt_q  <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= FIX;
        end
        FIX: begin
          if (div0_q) begin
            quotient_q  <= DIV0_Q;
            remainder_q <= dvd_q;
          end else if (ovf_q) begin
            quotient_q  <= dvd_q;
            remainder_q <= '0;
          end else begin
            quotient_q  <= neg_quo_q ? (~dvd_q + 1'b1) : dvd_q;
            remainder_q <= neg_rem_q ? (~prem_q + 1'b1) : prem_q;
          end
          div_zero_q  <= div0_q;
          overflow_q  <= ovf_q;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;
  assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// tb_seq_divider : directed and random checks of seq_divider against an
// arithmetic reference model. Revision 1.0
// ============================================================================
module tb_seq_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         is_signed = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;
  logic         overflow;

  int total = 0;
  int bad = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division (truncating) plus the flagged special cases
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output bit dz, output bit ov, output int lat);
    longint sa, sb, mag;
    int bits;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    dz = (b == '0);
    ov = s && (sa == -(longint'(1) << (W - 1))) && (sb == -1);
    if (dz) begin
      q = '1;
      r = a;
    end else if (ov) begin
      q = a;
      r = '0;
    end else begin
      q = W'(sa / sb);
      r = W'(sa % sb);
    end
    lat = W + 2;
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
    mag = (sa < 0) ? -sa : sa;
    bits = 0;
    while (mag > 0) begin
      bits++;
      mag = mag >> 1;
    end
    lat = ((bits < 1) ? 1 : bits) + 2;
`else
    mag = 0;
    bits = 0;
`endif
    if (dz || ov) lat = 2;
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                        input int hold, input string tag);
    logic [W-1:0] eq, er;
    bit ed, eo;
    int elat, edges, n;
    model(a, b, s, eq, er, ed, eo, elat);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    dividend  = a;
    divisor   = b;
    is_signed = s;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    in_valid  = 1'b0;
    dividend  = W'($urandom);
    divisor   = W'($urandom);
    is_signed = 1'($urandom);
    while (!out_valid && edges < 200) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk({tag, ".latency"}, 64'(edges), 64'(elat));
    chk({tag, ".quotient"}, 64'(quotient), 64'(eq));
    chk({tag, ".remainder"}, 64'(remainder), 64'(er));
    chk({tag, ".div_zero"}, 64'(div_zero), 64'(ed));
    chk({tag, ".overflow"}, 64'(overflow), 64'(eo));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      dividend = W'($urandom);
      divisor  = W'($urandom);
      @(negedge clk);
      chk({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, ".hold_quotient"}, 64'(quotient), 64'(eq));
      chk({tag, ".hold_remainder"}, 64'(remainder), 64'(er));
      chk({tag, ".hold_in_ready"}, 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".consumed"}, 64'(out_valid), 64'd0);
    chk({tag, ".in_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    bit rs;
    int extra;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.in_ready", 64'(in_ready), 64'd0);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.quotient", 64'(quotient), 64'd0);
    chk("rst.remainder", 64'(remainder), 64'd0);
    chk("rst.flags", 64'({div_zero, overflow}), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rst.in_ready_release", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("rst.in_ready_first_clk", 64'(in_ready), 64'd1);

    // Directed cases
    run_op(8'd200, 8'd3, 1'b0, 0, "u200_3");
    run_op(8'h9C, 8'd7, 1'b1, 0, "sneg100_7");
    run_op(8'd100, 8'hF9, 1'b1, 0, "s100_neg7");
    run_op(8'd7, 8'd0, 1'b0, 0, "div0");
    run_op(8'h80, 8'hFF, 1'b1, 0, "sovf");
    run_op(8'd128, 8'd255, 1'b0, 0, "u128_255");
    run_op(8'd0, 8'd5, 1'b1, 0, "zero_dvd");
    run_op(8'd45, 8'd6, 1'b0, 5, "hold");

    // Random operands, with biased hits on the special cases
    for (int k = 0; k < 60; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      if ($urandom_range(0, 9) == 0) rb = '0;
      if ($urandom_range(0, 9) == 0) begin
        ra = 8'h80;
        rb = 8'hFF;
      end
      run_op(ra, rb, rs, $urandom_range(0, 2), "rand");
    end

    // Reset during CALC aborts the division
    in_valid  = 1'b1;
    dividend  = 8'd100;
    divisor   = 8'd7;
    is_signed = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort.in_ready", 64'(in_ready), 64'd0);
    chk("abort.out_valid", 64'(out_valid), 64'd0);
    chk("abort.quotient", 64'(quotient), 64'd0);
    chk("abort.remainder", 64'(remainder), 64'd0);
    chk("abort.flags", 64'({div_zero, overflow}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    chk("abort.no_result", 64'(extra), 64'd0);
    run_op(8'd9, 8'd2, 1'b0, 0, "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
